// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared timing constants for the VGA raster generator.
//   - axis_timing_t : sync/back/active/front widths of one scan axis
//   - VGA_*         : common presets (640x480@60 is the default)
//   - SYNC_ACTIVE_* : sync polarity encodings (value driven while in sync)
//   - vga_axis_total: full period of one axis
// ---------------------------------------------------------------------------
package vga_pkg;

  typedef struct packed {
    int unsigned sync;
    int unsigned back;
    int unsigned active;
    int unsigned front;
  } axis_timing_t;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam axis_timing_t VGA_640X480_H = '{sync: 96, back: 48, active: 640, front: 16};
  localparam axis_timing_t VGA_640X480_V = '{sync: 2, back: 33, active: 480, front: 10};

  // 800x600 @ 60 Hz, 40 MHz pixel clock (positive sync)
  localparam axis_timing_t VGA_800X600_H = '{sync: 128, back: 88, active: 800, front: 40};
  localparam axis_timing_t VGA_800X600_V = '{sync: 4, back: 23, active: 600, front: 1};

  // 1024x768 @ 60 Hz, 65 MHz pixel clock (negative sync)
  localparam axis_timing_t VGA_1024X768_H = '{sync: 136, back: 160, active: 1024, front: 24};
  localparam axis_timing_t VGA_1024X768_V = '{sync: 6, back: 29, active: 768, front: 3};

  localparam int unsigned DEF_H_SYNC   = VGA_640X480_H.sync;
  localparam int unsigned DEF_H_BACK   = VGA_640X480_H.back;
  localparam int unsigned DEF_H_ACTIVE = VGA_640X480_H.active;
  localparam int unsigned DEF_H_FRONT  = VGA_640X480_H.front;
  localparam int unsigned DEF_V_SYNC   = VGA_640X480_V.sync;
  localparam int unsigned DEF_V_BACK   = VGA_640X480_V.back;
  localparam int unsigned DEF_V_ACTIVE = VGA_640X480_V.active;
  localparam int unsigned DEF_V_FRONT  = VGA_640X480_V.front;
  localparam bit          DEF_H_POL    = SYNC_ACTIVE_LOW;
  localparam bit          DEF_V_POL    = SYNC_ACTIVE_LOW;

  function automatic int unsigned vga_axis_total(input axis_timing_t t);
    return t.sync + t.back + t.active + t.front;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl_if
// Bundles the fetch side (scan enable, pixel address, frame buffer data) and
// the display side (delayed sync/valid and gated colour) of the VGA timing
// controller.
//   master : the timing controller
//   slave  : frame buffer / renderer plus the DAC pin consumer
// ---------------------------------------------------------------------------
interface vga_timing_ctrl_if #(
  parameter int CNT_W   = 10,
  parameter int COLOR_W = 8
);

  logic                 en;
  logic [3*COLOR_W-1:0] vga_data;
  logic [CNT_W-1:0]     h_addr;
  logic [CNT_W-1:0]     v_addr;
  logic                 addr_valid;
  logic                 line_start;
  logic                 frame_start;
  logic                 hsync;
  logic                 vsync;
  logic                 valid;
  logic [COLOR_W-1:0]   vga_r;
  logic [COLOR_W-1:0]   vga_g;
  logic [COLOR_W-1:0]   vga_b;

  modport master (
    input  en, vga_data,
    output h_addr, v_addr, addr_valid, line_start, frame_start,
    output hsync, vsync, valid, vga_r, vga_g, vga_b
  );

  modport slave (
    output en, vga_data,
    input  h_addr, v_addr, addr_valid, line_start, frame_start,
    input  hsync, vsync, valid, vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// Fixed-depth shift register with asynchronous reset to a caller-supplied
// value. DEPTH = 0 degenerates to a plain wire.
//   pclk    : clock
//   reset   : asynchronous, active-high; loads rst_val into every stage
//   rst_val : idle value held by all stages while in reset
//   d       : data entering the line
//   q       : data leaving the line, DEPTH cycles after d
// ---------------------------------------------------------------------------
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Clock, reset and idle value have no role without storage.
      logic unused_bypass;
      assign unused_bypass = ^{pclk, reset, rst_val};
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
// Parametrised VGA raster generator. Scans h_cnt/v_cnt over the full frame,
// presents the visible pixel address with zero latency, and delays sync and
// display-enable by PIPE_LAT cycles so that colour returned by a pipelined
// frame buffer arrives alongside its own sync/valid.
//   pclk, reset : pixel clock, asynchronous active-high reset
//   bus.en      : scan enable; low parks the raster at the origin
//   bus.vga_data: {r,g,b} for the address issued PIPE_LAT cycles earlier
//   bus.h_addr/v_addr/addr_valid/line_start/frame_start : fetch side
//   bus.hsync/vsync/valid/vga_r/vga_g/vga_b             : display side
// ---------------------------------------------------------------------------
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter bit          H_POL    = DEF_H_POL,
  parameter bit          V_POL    = DEF_V_POL,
  parameter int          PIPE_LAT = 2,
  parameter int          CNT_W    = 10,
  parameter int          COLOR_W  = 8
) (
  input logic               pclk,
  input logic               reset,
  vga_timing_ctrl_if.master bus
);

  localparam int unsigned H_TOTAL = vga_axis_total('{H_SYNC, H_BACK, H_ACTIVE, H_FRONT});
  localparam int unsigned V_TOTAL = vga_axis_total('{V_SYNC, V_BACK, V_ACTIVE, V_FRONT});

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_START    = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_START    = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] H_ACT_W    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_W    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_off;
  logic [CNT_W-1:0] v_off;
  logic             h_active;
  logic             v_active;
  logic             fetch_valid;
  logic             hs_raw;
  logic             vs_raw;
  logic             hs_d;
  logic             vs_d;
  logic             valid_d;

  // Raster counters: the line counter only advances on the horizontal wrap,
  // so both axes return to zero on the same edge at the end of a frame.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!bus.en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Offsets into the visible window double as the pixel address; the upper
  // bound test on the offset avoids needing a constant one past the window.
  assign h_off    = h_cnt - H_START;
  assign v_off    = v_cnt - V_START;
  assign h_active = (h_cnt >= H_START) && (h_off < H_ACT_W);
  assign v_active = (v_cnt >= V_START) && (v_off < V_ACT_W);

  assign fetch_valid     = bus.en & h_active & v_active;
  assign bus.addr_valid  = fetch_valid;
  assign bus.h_addr      = fetch_valid ? h_off : '0;
  assign bus.v_addr      = fetch_valid ? v_off : '0;
  assign bus.line_start  = fetch_valid & (h_off == '0);
  assign bus.frame_start = bus.en & (h_cnt == '0) & (v_cnt == '0);

  // With the scan disabled the counters park at the origin, which lies
  // inside both sync pulses; feeding the idle level instead lets the delayed
  // outputs drain to inactive after PIPE_LAT cycles.
  assign hs_raw = (bus.en && (h_cnt < H_SYNC_END)) ? H_POL : ~H_POL;
  assign vs_raw = (bus.en && (v_cnt < V_SYNC_END)) ? V_POL : ~V_POL;

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_LAT)
  ) u_sync_delay (
    .pclk    (pclk),
    .reset   (reset),
    .rst_val ({~H_POL, ~V_POL, 1'b0}),
    .d       ({hs_raw, vs_raw, fetch_valid}),
    .q       ({hs_d, vs_d, valid_d})
  );

  assign bus.hsync = hs_d;
  assign bus.vsync = vs_d;
  assign bus.valid = valid_d;

  assign {bus.vga_r, bus.vga_g, bus.vga_b} = valid_d ? bus.vga_data : '0;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_ctrl
// Drives two controllers side by side from one clock, reset and enable:
//   dut0 : default 640x480 timing, active-low sync, PIPE_LAT = 2
//   dut1 : tiny 16x8 raster, active-high sync, PIPE_LAT = 3
// The reference model tracks each raster as a linear pixel index within the
// frame and derives coordinates, windows and sync levels arithmetically. A
// small frame buffer emulation returns {h_addr,v_addr,A5} PIPE_LAT cycles
// after each address the DUT issues.
// ---------------------------------------------------------------------------
module tb_vga_timing_ctrl;

  logic pclk = 1'b0;
  logic reset;
  logic en;

  always #5 pclk = ~pclk;

  vga_timing_ctrl_if #(.CNT_W(10), .COLOR_W(8)) bus0 ();
  vga_timing_ctrl_if #(.CNT_W(10), .COLOR_W(8)) bus1 ();

  assign bus0.en = en;
  assign bus1.en = en;

  vga_timing_ctrl #(
    .PIPE_LAT (2)
  ) dut0 (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus0)
  );

  vga_timing_ctrl #(
    .H_SYNC (4), .H_BACK (2), .H_ACTIVE (8), .H_FRONT (2),
    .V_SYNC (2), .V_BACK (1), .V_ACTIVE (4), .V_FRONT (1),
    .H_POL (1'b1), .V_POL (1'b1), .PIPE_LAT (3)
  ) dut1 (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus1)
  );

  // Reference parameters, one column per DUT
  int unsigned m_hs [2] = '{96, 4};
  int unsigned m_hb [2] = '{48, 2};
  int unsigned m_ha [2] = '{640, 8};
  int unsigned m_hf [2] = '{16, 2};
  int unsigned m_vs [2] = '{2, 2};
  int unsigned m_vb [2] = '{33, 1};
  int unsigned m_va [2] = '{480, 4};
  int unsigned m_vf [2] = '{10, 1};
  bit          m_hpol [2] = '{1'b0, 1'b1};
  bit          m_vpol [2] = '{1'b0, 1'b1};
  int          m_lat  [2] = '{2, 3};

  typedef struct {
    bit          hs;
    bit          vs;
    bit          val;
    logic [23:0] col;
  } disp_t;

  int unsigned pos [2];
  disp_t       hist [2][8];
  logic [23:0] fb [2][8];

  int checks = 0;
  int errors = 0;

  function automatic int unsigned frameLen(input int id);
    return (m_hs[id] + m_hb[id] + m_ha[id] + m_hf[id]) *
           (m_vs[id] + m_vb[id] + m_va[id] + m_vf[id]);
  endfunction

  // Everything the raster should present at linear position p.
  function automatic void coords(input int id, input int unsigned p, input bit en_i,
                                 output bit av, output int unsigned ha, output int unsigned va,
                                 output bit hs, output bit vs, output bit fs);
    int unsigned ht, h, v, hstart, vstart;
    ht     = m_hs[id] + m_hb[id] + m_ha[id] + m_hf[id];
    h      = p % ht;
    v      = p / ht;
    hstart = m_hs[id] + m_hb[id];
    vstart = m_vs[id] + m_vb[id];
    av = en_i && (h >= hstart) && (h < hstart + m_ha[id]) &&
         (v >= vstart) && (v < vstart + m_va[id]);
    ha = av ? h - hstart : 0;
    va = av ? v - vstart : 0;
    hs = (en_i && h < m_hs[id]) ? m_hpol[id] : !m_hpol[id];
    vs = (en_i && v < m_vs[id]) ? m_vpol[id] : !m_vpol[id];
    fs = en_i && (p == 0);
  endfunction

  function automatic disp_t rawDisp(input int id);
    bit av, hs, vs, fs;
    int unsigned ha, va;
    disp_t d;
    coords(id, pos[id], en, av, ha, va, hs, vs, fs);
    d.hs  = hs;
    d.vs  = vs;
    d.val = av;
    d.col = av ? {ha[7:0], va[7:0], 8'hA5} : 24'h0;
    return d;
  endfunction

  task automatic modelReset(input int id);
    pos[id] = 0;
    for (int i = 0; i < 8; i++) begin
      hist[id][i].hs  = !m_hpol[id];
      hist[id][i].vs  = !m_vpol[id];
      hist[id][i].val = 1'b0;
      hist[id][i].col = 24'h0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkDut(input int id, input logic av_o, input logic [9:0] ha_o,
                          input logic [9:0] va_o, input logic ls_o, input logic fs_o,
                          input logic hs_o, input logic vs_o, input logic val_o,
                          input logic [23:0] col_o);
    bit av, hs, vs, fs;
    int unsigned ha, va;
    disp_t d;
    coords(id, pos[id], en, av, ha, va, hs, vs, fs);
    d = hist[id][m_lat[id]-1];
    chk($sformatf("dut%0d.addr_valid", id), 32'(av_o), 32'(av));
    chk($sformatf("dut%0d.h_addr", id), 32'(ha_o), ha);
    chk($sformatf("dut%0d.v_addr", id), 32'(va_o), va);
    chk($sformatf("dut%0d.line_start", id), 32'(ls_o), 32'(av && ha == 0));
    chk($sformatf("dut%0d.frame_start", id), 32'(fs_o), 32'(fs));
    chk($sformatf("dut%0d.hsync", id), 32'(hs_o), 32'(d.hs));
    chk($sformatf("dut%0d.vsync", id), 32'(vs_o), 32'(d.vs));
    chk($sformatf("dut%0d.valid", id), 32'(val_o), 32'(d.val));
    chk($sformatf("dut%0d.colour", id), 32'(col_o), 32'(d.val ? d.col : 24'h0));
  endtask

  task automatic checkOutput();
    checkDut(0, bus0.addr_valid, bus0.h_addr, bus0.v_addr, bus0.line_start, bus0.frame_start,
             bus0.hsync, bus0.vsync, bus0.valid, {bus0.vga_r, bus0.vga_g, bus0.vga_b});
    checkDut(1, bus1.addr_valid, bus1.h_addr, bus1.v_addr, bus1.line_start, bus1.frame_start,
             bus1.hsync, bus1.vsync, bus1.valid, {bus1.vga_r, bus1.vga_g, bus1.vga_b});
  endtask

  // One pixel clock: capture what the edge will sample, let it happen, move
  // the model across it, then present the next inputs and check.
  task automatic applyStimulus(input logic next_en, input logic next_reset);
    disp_t       raw [2];
    logic [23:0] fb_in [2];
    raw[0]   = rawDisp(0);
    raw[1]   = rawDisp(1);
    fb_in[0] = {bus0.h_addr[7:0], bus0.v_addr[7:0], 8'hA5};
    fb_in[1] = {bus1.h_addr[7:0], bus1.v_addr[7:0], 8'hA5};
    @(posedge pclk);
    @(negedge pclk);
    for (int id = 0; id < 2; id++) begin
      if (reset) begin
        modelReset(id);
      end else begin
        for (int i = 7; i > 0; i--) hist[id][i] = hist[id][i-1];
        hist[id][0] = raw[id];
        pos[id] = en ? (pos[id] + 1) % frameLen(id) : 0;
      end
      for (int i = 7; i > 0; i--) fb[id][i] = fb[id][i-1];
      fb[id][0] = fb_in[id];
    end
    bus0.vga_data = fb[0][m_lat[0]-1];
    bus1.vga_data = fb[1][m_lat[1]-1];
    reset = next_reset;
    en    = next_en;
    if (next_reset) begin
      modelReset(0);
      modelReset(1);
    end
    #1;
    checkOutput();
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1;
    en    = 1'b0;
    bus0.vga_data = '0;
    bus1.vga_data = '0;
    for (int i = 0; i < 8; i++) begin
      fb[0][i] = '0;
      fb[1][i] = '0;
    end
    modelReset(0);
    modelReset(1);
    #2;
    $display("[TB] reset held");
    checkOutput();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);

    $display("[TB] release reset, continuous scan into the visible area");
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 31000; i++) applyStimulus(1'b1, 1'b0);

    $display("[TB] enable dropped for 5 cycles mid-line");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 600; i++) applyStimulus(1'b1, 1'b0);

    $display("[TB] random enable gaps");
    for (int i = 0; i < 3000; i++) applyStimulus(($urandom_range(0, 99) < 95) ? 1'b1 : 1'b0, 1'b0);

    $display("[TB] asynchronous reset pulse mid-line");
    n = $urandom_range(50, 700);
    for (int unsigned i = 0; i < n; i++) applyStimulus(1'b1, 1'b0);
    n = $urandom_range(1, 3);
    for (int unsigned i = 0; i < n; i++) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 2000; i++) applyStimulus(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
